// File: rtl/oam_dma.sv
// Sprite DMA: on a CPU write to $4014, stalls the CPU and copies one 256-byte
// page into OAM starting at the current OAM address. Sequencing advances on ce.
module oam_dma (
   input  logic        clock,
   input  logic        reset,
   input  logic        ce,
   input  logic [15:0] cpu_a,
   input  logic [7:0]  cpu_o,
   input  logic        cpu_w,
   input  logic [7:0]  oam_base,
   input  logic [7:0]  dma_i,
   output logic        halt,
   output logic        busy,
   output logic [15:0] dma_a,
   output logic [7:0]  oam_a,
   output logic [7:0]  oam_o,
   output logic        oam_w
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HALT,
      S_ALIGN,
      S_READ,
      S_WRITE
   } state_t;

   state_t      state_q, state_d;
   logic        odd_q, odd_d;
   logic [7:0]  idx_q, idx_d;
   logic [7:0]  data_q, data_d;
   logic [7:0]  page_q, page_d;
   logic [7:0]  base_q, base_d;

   always_comb begin
      state_d = state_q;
      odd_d   = ce ? ~odd_q : odd_q;
      idx_d   = idx_q;
      data_d  = data_q;
      page_d  = page_q;
      base_d  = base_q;
      dma_a   = 16'h0000;
      oam_a   = 8'h00;
      oam_w   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (ce && cpu_w && (cpu_a == 16'h4014)) begin
               page_d  = cpu_o;
               base_d  = oam_base;
               idx_d   = 8'h00;
               state_d = S_HALT;
            end
         end
         S_HALT: begin
            // An extra alignment cycle keeps reads on the even CPU cycle
            if (ce) state_d = odd_q ? S_ALIGN : S_READ;
         end
         S_ALIGN: begin
            if (ce) state_d = S_READ;
         end
         S_READ: begin
            dma_a = {page_q, idx_q};
            if (ce) begin
               data_d  = dma_i;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            oam_a = base_q + idx_q;
            oam_w = ce;
            if (ce) begin
               idx_d   = idx_q + 8'h01;
               state_d = (idx_q == 8'hFF) ? S_IDLE : S_READ;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         odd_q   <= 1'b0;
         idx_q   <= 8'h00;
         data_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         odd_q   <= odd_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
      end
   end

   // Page and base are only meaningful once a trigger has loaded them
   always_ff @(posedge clock) begin
      page_q <= page_d;
      base_q <= base_d;
   end

   assign halt  = (state_q != S_IDLE);
   assign busy  = halt;
   assign oam_o = data_q;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: RAM model, scoreboard of expected OAM writes,
// and an OAM image built from observed write pulses.
module tb_oam_dma;

   logic        clock = 1'b0;
   logic        reset;
   logic        ce;
   logic [15:0] cpu_a;
   logic [7:0]  cpu_o;
   logic        cpu_w;
   logic [7:0]  oam_base;
   logic [7:0]  dma_i;
   logic        halt;
   logic        busy;
   logic [15:0] dma_a;
   logic [7:0]  oam_a;
   logic [7:0]  oam_o;
   logic        oam_w;

   oam_dma dut (
      .clock    (clock),
      .reset    (reset),
      .ce       (ce),
      .cpu_a    (cpu_a),
      .cpu_o    (cpu_o),
      .cpu_w    (cpu_w),
      .oam_base (oam_base),
      .dma_i    (dma_i),
      .halt     (halt),
      .busy     (busy),
      .dma_a    (dma_a),
      .oam_a    (oam_a),
      .oam_o    (oam_o),
      .oam_w    (oam_w)
   );

   always #10 clock = ~clock;

   logic [7:0] ram [0:2047];
   logic [7:0] oam_img [0:255];
   logic [7:0] exp_a [$];
   logic [7:0] exp_d [$];
   int checks = 0;
   int errors = 0;
   int wr_cnt = 0;
   int stall_cnt = 0;
   logic tb_odd = 1'b0;

   assign dma_i = ram[dma_a[10:0]];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Monitor: counts stalled CPU cycles and scores every OAM write pulse
   always @(negedge clock) begin
      if (!reset) begin
         if (ce && halt) stall_cnt++;
         if (oam_w) begin
            check("oam_w_with_ce", {31'd0, ce}, 32'd1);
            if (exp_a.size() == 0) begin
               check("unexpected_oam_w", 32'd1, 32'd0);
            end else begin
               check("oam_a", {24'd0, oam_a}, {24'd0, exp_a.pop_front()});
               check("oam_o", {24'd0, oam_o}, {24'd0, exp_d.pop_front()});
            end
            oam_img[oam_a] = oam_o;
            wr_cnt++;
         end
      end
   end

   task automatic do_ce(input int idle);
      ce = 1'b1;
      @(posedge clock);
      #1;
      ce = 1'b0;
      tb_odd = ~tb_odd;
      repeat (idle) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      ce = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      tb_odd = 1'b0;
   endtask

   // Trigger so that the HALT cycle sees the requested parity; returns expected stall
   task automatic trigger(input logic [7:0] page, input logic [7:0] base,
                          input logic halt_odd, output int exp_stall);
      if (tb_odd == halt_odd) do_ce(0);
      exp_stall = 513 + (halt_odd ? 1 : 0);
      for (int i = 0; i < 256; i++) begin
         exp_a.push_back(base + 8'(i));
         exp_d.push_back(ram[{page[2:0], 8'(i)}]);
      end
      wr_cnt = 0;
      stall_cnt = 0;
      cpu_a = 16'h4014;
      cpu_o = page;
      cpu_w = 1'b1;
      oam_base = base;
      do_ce(0);
      cpu_w = 1'b0;
      cpu_a = 16'h0000;
      check("halt_rise", {31'd0, halt}, 32'd1);
      check("busy_rise", {31'd0, busy}, 32'd1);
      check("dma_a_in_halt", {16'd0, dma_a}, 32'd0);
   endtask

   // mode 0: back-to-back ce, 1: spurious $4014 write mid-transfer, 2: irregular ce
   task automatic run_xfer(input int mode, input int exp_stall, input string tag);
      int n;
      n = 0;
      while (halt && n < 4000) begin
         if (mode == 1 && n == 50) begin
            cpu_a = 16'h4014;
            cpu_o = 8'h07;
            cpu_w = 1'b1;
         end
         if (mode == 2) do_ce((n % 17 == 5) ? 6 : 3);
         else do_ce(0);
         cpu_w = 1'b0;
         cpu_a = 16'h0000;
         n++;
      end
      check({tag, "_done"}, {31'd0, halt}, 32'd0);
      check({tag, "_stall"}, stall_cnt, exp_stall);
      check({tag, "_writes"}, wr_cnt, 256);
      check({tag, "_queue_empty"}, exp_a.size(), 0);
   endtask

   task automatic check_image(input logic [7:0] page, input logic [7:0] base, input string tag);
      int bad;
      bad = 0;
      for (int i = 0; i < 256; i++)
         if (oam_img[8'(base + 8'(i))] !== ram[{page[2:0], 8'(i)}]) bad++;
      check(tag, bad, 0);
   endtask

   initial begin
      int es;
      int n;
      int bad;
      for (int i = 0; i < 2048; i++) ram[i] = 8'h00;
      for (int i = 0; i < 256; i++) begin
         ram[12'h200 + i] = 8'(i) ^ 8'hA5;
         ram[12'h300 + i] = 8'(i) ^ 8'h5A;
         ram[12'h700 + i] = 8'(i) ^ 8'h33;
         oam_img[i] = 8'hEE;
      end
      ce = 1'b0;
      cpu_a = 16'h0000;
      cpu_o = 8'h00;
      cpu_w = 1'b0;
      oam_base = 8'h00;
      do_reset();

      check("rst_halt", {31'd0, halt}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_oam_w", {31'd0, oam_w}, 32'd0);
      check("rst_dma_a", {16'd0, dma_a}, 32'd0);
      check("rst_oam_a", {24'd0, oam_a}, 32'd0);
      check("rst_oam_o", {24'd0, oam_o}, 32'd0);

      // Even-parity transfer
      trigger(8'h02, 8'h00, 1'b0, es);
      run_xfer(0, es, "even");
      check_image(8'h02, 8'h00, "even_image");
      check("idle_dma_a", {16'd0, dma_a}, 32'd0);

      // Odd-parity transfer: one extra aligned cycle
      for (int i = 0; i < 256; i++) oam_img[i] = 8'hEE;
      trigger(8'h02, 8'h00, 1'b1, es);
      run_xfer(0, es, "odd");
      check_image(8'h02, 8'h00, "odd_image");

      // OAM address wrap
      trigger(8'h03, 8'hF0, 1'b0, es);
      run_xfer(0, es, "wrap");
      check("wrap_b0", {24'd0, oam_img[8'hF0]}, {24'd0, ram[12'h300]});
      check("wrap_b15", {24'd0, oam_img[8'hFF]}, {24'd0, ram[12'h30F]});
      check("wrap_b16", {24'd0, oam_img[8'h00]}, {24'd0, ram[12'h310]});
      check("wrap_b255", {24'd0, oam_img[8'hEF]}, {24'd0, ram[12'h3FF]});
      check_image(8'h03, 8'hF0, "wrap_image");

      // Reset after the 100th write
      trigger(8'h02, 8'h00, 1'b0, es);
      n = 0;
      while (wr_cnt < 100 && n < 1000) begin
         do_ce(0);
         n++;
      end
      check("pre_reset_writes", wr_cnt, 100);
      reset = 1'b1;
      @(posedge clock);
      #1;
      check("reset_halt_fall", {31'd0, halt}, 32'd0);
      reset = 1'b0;
      tb_odd = 1'b0;
      exp_a.delete();
      exp_d.delete();
      repeat (20) do_ce(0);
      check("post_reset_writes", wr_cnt, 100);
      check("post_reset_halt", {31'd0, halt}, 32'd0);
      bad = 0;
      for (int k = 100; k < 256; k++)
         if (oam_img[k] !== ram[12'h300 + ((k - 8'hF0) & 8'hFF)]) bad++;
      check("reset_untouched", bad, 0);
      trigger(8'h02, 8'h00, 1'b1, es);
      run_xfer(0, es, "after_reset");
      check_image(8'h02, 8'h00, "after_reset_image");

      // Spurious $4014 write while busy
      for (int i = 0; i < 256; i++) oam_img[i] = 8'hEE;
      trigger(8'h02, 8'h00, 1'b0, es);
      run_xfer(1, es, "spurious");
      check_image(8'h02, 8'h00, "spurious_image");

      // Idle accesses that must not trigger
      wr_cnt = 0;
      cpu_a = 16'h4015;
      cpu_o = 8'h02;
      cpu_w = 1'b1;
      do_ce(0);
      cpu_a = 16'h4014;
      cpu_w = 1'b0;
      do_ce(0);
      cpu_a = 16'h0000;
      check("no_trig_halt", {31'd0, halt}, 32'd0);
      repeat (4) do_ce(0);
      check("no_trig_halt_late", {31'd0, halt}, 32'd0);
      check("no_trig_writes", wr_cnt, 0);

      // Irregular ce spacing
      for (int i = 0; i < 256; i++) oam_img[i] = 8'hEE;
      trigger(8'h02, 8'h00, 1'b0, es);
      run_xfer(2, es, "irregular");
      check_image(8'h02, 8'h00, "irregular_image");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
